// File: rtl/row_dec_pkg.sv
// row_dec_pkg: state encoding and counter sizing helper shared by the row decoder
package row_dec_pkg;
   typedef enum logic [1:0] {IDLE, PRE, ACT, DONE} state_t;
   function automatic int max(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/row_dec_seq_onehot_dec.sv
// onehot_dec: enabled address to one-hot row select, all-zero when disabled or out of range
module onehot_dec
   import row_dec_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [DEPTH-1:0]  sel
);
   always_comb sel = (en && 32'(addr) < DEPTH) ? DEPTH'(1) << addr : '0;
endmodule

// File: rtl/row_dec_seq.sv
// row_dec_seq: sequenced precharge-then-activate row decoder with one-hot wordline select
// Optional ROW_DEC_RANGE_CHECK_EN rejects out-of-range rows with an err pulse
module row_dec_seq
   import row_dec_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PRE_CYCLES = 1,
   parameter int ACT_CYCLES = 2,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              pre,
   output logic [DEPTH-1:0]  sel,
   output logic              done,
   output logic              err
);
   localparam int CNT_W = $clog2(max(PRE_CYCLES, ACT_CYCLES) + 1);
   if (DEPTH < 2 || PRE_CYCLES < 1 || ACT_CYCLES < 1) begin : g_param_err
      $error("row_dec_seq: parameter out of range");
   end
   state_t state, state_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic oob_req;
`ifdef ROW_DEC_RANGE_CHECK_EN
   logic oob_q;
   assign oob_req = 32'(req_addr) >= DEPTH;
   assign oob_q = 32'(addr_q) >= DEPTH;
   assign done = !rst && state == DONE && !oob_q;
   assign err = !rst && state == DONE && oob_q;
`else
   assign oob_req = 1'b0;
   assign done = !rst && state == DONE;
   assign err = 1'b0;
`endif
   assign req_ready = !rst && state == IDLE;
   assign pre = !rst && state == PRE;
   always_comb begin
      state_n = state;
      addr_n = addr_q;
      cnt_n = cnt;
      unique case (state)
         IDLE: if (req_valid) begin
            state_n = oob_req ? DONE : PRE;
            addr_n = req_addr;
            cnt_n = CNT_W'(PRE_CYCLES - 1);
         end
         PRE: begin
            state_n = cnt == '0 ? ACT : PRE;
            cnt_n = cnt == '0 ? CNT_W'(ACT_CYCLES - 1) : cnt - 1'b1;
         end
         ACT: begin
            state_n = cnt == '0 ? DONE : ACT;
            cnt_n = cnt == '0 ? '0 : cnt - 1'b1;
         end
         DONE: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr_q <= '0;
         cnt <= '0;
      end else begin
         state <= state_n;
         addr_q <= addr_n;
         cnt <= cnt_n;
      end
   end
   onehot_dec #(.DEPTH(DEPTH)) u_dec (
      .en(!rst && state == ACT),
      .addr(addr_q),
      .sel(sel)
   );
endmodule

// File: tb/tb_row_dec_seq.sv
// tb_row_dec_seq: three configurations of row_dec_seq checked each cycle against a timing model
module tb_row_dec_seq;
   localparam int NP[3] = '{1, 3, 1};
   localparam int NA[3] = '{2, 1, 2};
   localparam int ND[3] = '{8, 16, 6};
   localparam int MASK[3] = '{7, 15, 7};
`ifdef ROW_DEC_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif
   logic clk = 0, rst = 1, vld = 1;
   logic [3:0] ain = '0;
   logic [2:0] rdy, pre, done, err;
   logic [7:0] sel0;
   logic [15:0] sel1;
   logic [5:0] sel2;
   logic [15:0] osel[3];
   int checks = 0, errors = 0, cyc = 0, n;
   bit busy[3], shortp[3], acc[3];
   int t[3], maddr[3];
   always #5 clk = ~clk;
   row_dec_seq #(.DEPTH(8), .PRE_CYCLES(1), .ACT_CYCLES(2)) u0 (
      .clk(clk), .rst(rst), .req_valid(vld), .req_ready(rdy[0]), .req_addr(ain[2:0]),
      .pre(pre[0]), .sel(sel0), .done(done[0]), .err(err[0]));
   row_dec_seq #(.DEPTH(16), .PRE_CYCLES(3), .ACT_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .req_valid(vld), .req_ready(rdy[1]), .req_addr(ain),
      .pre(pre[1]), .sel(sel1), .done(done[1]), .err(err[1]));
   row_dec_seq #(.DEPTH(6), .PRE_CYCLES(1), .ACT_CYCLES(2)) u2 (
      .clk(clk), .rst(rst), .req_valid(vld), .req_ready(rdy[2]), .req_addr(ain[2:0]),
      .pre(pre[2]), .sel(sel2), .done(done[2]), .err(err[2]));
   assign osel[0] = 16'(sel0);
   assign osel[1] = sel1;
   assign osel[2] = 16'(sel2);
   function automatic int len(input int d);
      return shortp[d] ? 1 : NP[d] + NA[d] + 1;
   endfunction
   task automatic chk(input string tag, input int d, input logic [15:0] o, input logic [15:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s dut%0d cycle %0d observed %h expected %h", tag, d, cyc, o, e);
      end
   endtask
   // t counts cycles since the accepting edge; all expectations follow from it
   task automatic step(input logic v, input logic [3:0] a, input logic r);
      vld = v;
      ain = a;
      rst = r;
      for (int d = 0; d < 3; d++) acc[d] = !r && v && !busy[d];
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
         if (r) busy[d] = 0;
         else if (busy[d]) begin
            t[d]++;
            if (t[d] > len(d)) busy[d] = 0;
         end else if (v) begin
            busy[d] = 1;
            t[d] = 1;
            maddr[d] = int'(a) & MASK[d];
            shortp[d] = RC && maddr[d] >= ND[d];
         end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         bit live;
         live = !r && busy[d] && !shortp[d];
         chk("ready", d, 16'(rdy[d]), 16'(!r && !busy[d]));
         chk("pre", d, 16'(pre[d]), 16'(live && t[d] <= NP[d]));
         chk("sel", d, osel[d], (live && t[d] > NP[d] && t[d] <= NP[d] + NA[d] && maddr[d] < ND[d])
             ? 16'(1) << maddr[d] : 16'h0);
         chk("done", d, 16'(done[d]), 16'(live && t[d] == NP[d] + NA[d] + 1));
         chk("err", d, 16'(err[d]), 16'(!r && busy[d] && shortp[d]));
      end
   endtask
   initial begin
      step(1, 4'd2, 1);
      step(1, 4'd2, 1);
      step(0, 4'd0, 0);
      for (int i = 0; i < 16; i++) begin
         n = 0;
         do begin
            step(1, 4'(i), 0);
            n++;
         end while (!acc[0] && n < 20);
         chk("sweep_wait", 0, 16'(acc[0]), 16'h1);
      end
      repeat (20) step(1, 4'd5, 0);
      n = 0;
      while (busy[0] && n < 20) begin
         step(0, 4'd0, 0);
         n++;
      end
      step(1, 4'd3, 0);
      n = 0;
      while (!(busy[0] && t[0] == NP[0] + 1) && n < 20) begin
         step(0, 4'd0, 0);
         n++;
      end
      chk("act_wait", 0, 16'(busy[0] && t[0] == NP[0] + 1), 16'h1);
      step(0, 4'd0, 1);
      step(0, 4'd0, 0);
      step(1, 4'd3, 0);
      repeat (8) step(0, 4'd0, 0);
      step(1, 4'd7, 0);
      repeat (8) step(0, 4'd0, 0);
      step(1, 4'd15, 0);
      repeat (8) step(0, 4'd0, 0);
      repeat (400) step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 49) == 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
